// File: rtl/shift_reg_sequencer.sv
// Command sequencer for a bidirectional shift register:
// serial load, rotate-by-N and clear over a valid/ready handshake.
module shift_reg_sequencer #(
  parameter int MSB   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [MSB-1:0]   cmd_data,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_circular,
  output logic             sr_d,
  output logic             sr_rstn,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_SHIFT = 2'b00;
  localparam logic [1:0] OP_ROT   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [1:0] OP_RSV   = 2'b11;

  localparam logic [CNT_W-1:0] SAT =
    (MSB < 2**CNT_W) ? CNT_W'(MSB) : '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CLR,
    DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] step_q;
  logic [CNT_W-1:0] last_q;
  logic [MSB-1:0]   data_q;
  logic             rot_q;

  logic [CNT_W-1:0] n_d;
  logic             run_d;
  logic             is_shift;
  logic             is_rot;

  always_comb begin
    is_shift = (cmd_op == OP_SHIFT);
    is_rot   = (cmd_op == OP_ROT);
    n_d      = cmd_count;
    if (is_shift && (cmd_count > SAT)) begin
      n_d = SAT;
    end
    run_d = (is_shift || is_rot) && (n_d != '0);
  end

  // Data bits are consumed LSB first by shifting the latched copy right.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      last_q      <= '0;
      data_q      <= '0;
      rot_q       <= 1'b0;
      cmd_ready   <= 1'b1;
      sr_en       <= 1'b0;
      sr_dir      <= 1'b0;
      sr_circular <= 1'b0;
      sr_d        <= 1'b0;
      sr_rstn     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      sr_rstn     <= 1'b1;
      sr_en       <= 1'b0;
      sr_circular <= 1'b0;
      sr_d        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            sr_dir    <= cmd_dir;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            step_q    <= '0;
            last_q    <= n_d - CNT_W'(1);
            data_q    <= cmd_data >> 1;
            rot_q     <= is_rot;
            if (run_d) begin
              state_q     <= RUN;
              sr_en       <= 1'b1;
              sr_circular <= is_rot;
              sr_d        <= is_shift & cmd_data[0];
            end else if (cmd_op == OP_CLR) begin
              state_q <= CLR;
              sr_rstn <= 1'b0;
            end else begin
              state_q <= DONE;
              done    <= 1'b1;
              err     <= (cmd_op == OP_RSV);
            end
          end
        end
        RUN: begin
          if (step_q == last_q) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            step_q      <= step_q + CNT_W'(1);
            sr_en       <= 1'b1;
            sr_circular <= rot_q;
            sr_d        <= ~rot_q & data_q[0];
            data_q      <= data_q >> 1;
          end
        end
        CLR: begin
          state_q <= DONE;
          done    <= 1'b1;
        end
        DONE: begin
          state_q   <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: command table with a
// scoreboard plus hand-written reset and back-to-back cases.
module tb_shift_reg_sequencer;

  localparam int MSB   = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic [MSB-1:0]   cmd_data;
  logic             sr_en;
  logic             sr_dir;
  logic             sr_circular;
  logic             sr_d;
  logic             sr_rstn;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  shift_reg_sequencer #(.MSB(MSB), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dir    (cmd_dir),
    .cmd_count  (cmd_count),
    .cmd_data   (cmd_data),
    .sr_en      (sr_en),
    .sr_dir     (sr_dir),
    .sr_circular(sr_circular),
    .sr_d       (sr_d),
    .sr_rstn    (sr_rstn),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Shift register model: dir=0 shifts right (d into MSB),
  // dir=1 shifts left (d into LSB).
  logic [7:0] sreg = 8'h00;
  always @(posedge clk) begin
    if (!sr_rstn) sreg <= 8'h00;
    else if (sr_en) begin
      if (sr_dir)
        sreg <= {sreg[6:0], sr_circular ? sreg[7] : sr_d};
      else
        sreg <= {sr_circular ? sreg[0] : sr_d, sreg[7:1]};
    end
  end

  typedef struct {
    logic [1:0] op;
    logic       dir;
    logic [3:0] cnt;
    logic [7:0] data;
    logic [7:0] reg_exp;
  } vec_t;

  typedef struct {
    int         n;
    int         done_at;
    logic [7:0] bits;
    logic       err;
    int         clr;
    logic       circ;
    logic       dir;
    logic [7:0] reg_exp;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[11];
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  function automatic exp_t predict(input vec_t v);
    exp_t e;
    e.n = 0;
    if (v.op == 2'b00) e.n = (v.cnt > 8) ? 8 : int'(v.cnt);
    if (v.op == 2'b01) e.n = int'(v.cnt);
    e.bits = 8'h00;
    for (int i = 0; i < 8; i++)
      if (v.op == 2'b00 && i < e.n) e.bits[i] = v.data[i];
    e.done_at = (v.op == 2'b10) ? 2 : e.n + 1;
    e.err     = (v.op == 2'b11);
    e.clr     = (v.op == 2'b10) ? 1 : 0;
    e.circ    = (v.op == 2'b01);
    e.dir     = v.dir;
    e.reg_exp = v.reg_exp;
    return e;
  endfunction

  task automatic issue(input vec_t v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_op    = v.op;
    cmd_dir   = v.dir;
    cmd_count = v.cnt;
    cmd_data  = v.data;
    cmd_valid = 1'b1;
    sb.push_back(predict(v));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic collect(input string nm);
    exp_t       e;
    int         n, clr, done_at;
    logic [7:0] bits;
    logic       errv, circ_ok, dir_ok, busy_ok;
    n = 0; clr = 0; done_at = 0; bits = 8'h00;
    errv = 1'b0; circ_ok = 1'b1;
    dir_ok = 1'b1; busy_ok = 1'b1;
    e = sb.pop_front();
    for (int c = 1; c <= 40; c++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (sr_dir !== e.dir) dir_ok = 1'b0;
      if (sr_en === 1'b1) begin
        if (n < 8) bits[n] = sr_d;
        else if (sr_d !== 1'b0) bits = 8'hxx;
        if (sr_circular !== e.circ) circ_ok = 1'b0;
        n++;
      end else if (sr_circular !== 1'b0) circ_ok = 1'b0;
      if (sr_rstn === 1'b0) clr++;
      if (done === 1'b1) begin
        done_at = c;
        errv    = err;
        break;
      end
      @(negedge clk);
    end
    if (done_at == 0) begin
      chk({nm, "_done_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_steps"},   n,       e.n);
    chk({nm, "_done_at"}, done_at, e.done_at);
    chk({nm, "_bits"},    bits,    e.bits);
    chk({nm, "_err"},     errv,    e.err);
    chk({nm, "_clr"},     clr,     e.clr);
    chk({nm, "_circ"},    circ_ok, 1);
    chk({nm, "_dir"},     dir_ok,  1);
    chk({nm, "_busy"},    busy_ok, 1);
    @(negedge clk);
    chk({nm, "_idle"},
        {cmd_ready, busy, done, err, sr_en}, 5'b10000);
    chk({nm, "_reg"},     sreg,    e.reg_exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, gap, last_acc, en_cnt;
    tbl[0]  = '{2'd0, 1'b0, 4'd8,  8'hA5, 8'hA5};
    tbl[1]  = '{2'd0, 1'b1, 4'd8,  8'h1E, 8'h78};
    tbl[2]  = '{2'd2, 1'b0, 4'd3,  8'hFF, 8'h00};
    tbl[3]  = '{2'd0, 1'b0, 4'd15, 8'h3C, 8'h3C};
    tbl[4]  = '{2'd0, 1'b0, 4'd0,  8'hFF, 8'h3C};
    tbl[5]  = '{2'd2, 1'b1, 4'd0,  8'h00, 8'h00};
    tbl[6]  = '{2'd0, 1'b1, 4'd1,  8'h01, 8'h01};
    tbl[7]  = '{2'd1, 1'b0, 4'd3,  8'hFF, 8'h20};
    tbl[8]  = '{2'd1, 1'b1, 4'd10, 8'h00, 8'h80};
    tbl[9]  = '{2'd3, 1'b0, 4'd5,  8'hFF, 8'h80};
    tbl[10] = '{2'd1, 1'b0, 4'd0,  8'h00, 8'h80};

    rst = 1'b1; cmd_valid = 1'b0;
    cmd_op = 2'd0; cmd_dir = 1'b0;
    cmd_count = '0; cmd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {cmd_ready, sr_en, sr_dir, sr_circular,
         sr_d, sr_rstn, busy, done, err},
        9'b1_0000_1000);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      issue(tbl[i]);
      collect($sformatf("vec%0d", i));
    end

    // cmd_valid held high: accepts only from IDLE, every N+2
    cmd_op = 2'd0; cmd_dir = 1'b0;
    cmd_count = 4'd2; cmd_data = 8'h03;
    cmd_valid = 1'b1;
    acc = 0; gap = 0; last_acc = -1; en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (sr_en) en_cnt++;
      if (cmd_valid && cmd_ready) begin
        if (last_acc >= 0) gap = i - last_acc;
        last_acc = i;
        acc++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", acc, 3);
    chk("b2b_period", gap, 4);
    chk("b2b_en_cycles", en_cnt, 5);

    issue('{2'd2, 1'b0, 4'd0, 8'h00, 8'h00});
    collect("clr_pre_rst");

    // reset after 3 steps of an 8-step load
    cmd_op = 2'd0; cmd_dir = 1'b0;
    cmd_count = 4'd8; cmd_data = 8'hFF;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (sr_en) en_cnt++;
      if (i < 2) @(negedge clk);
    end
    chk("midrst_steps", en_cnt, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs",
        {cmd_ready, sr_en, sr_circular,
         sr_d, sr_rstn, busy, done, err},
        8'b1000_1000);
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) acc++;
      @(negedge clk);
    end
    chk("midrst_no_done", acc, 0);
    chk("midrst_reg", sreg, 8'hE0);

    // reset wins over a simultaneous command
    cmd_op = 2'd0; cmd_count = 4'd4;
    cmd_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    chk("rst_priority",
        {cmd_ready, busy, sr_en, done}, 4'b1000);
    @(negedge clk);
    chk("rst_priority_idle",
        {cmd_ready, busy, sr_en}, 3'b100);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
